// File: rtl/mode_counter_if.sv
// rtl/mode_counter_if.sv - control/status bundle for mode_counter
interface mode_counter_if #(
    parameter int WIDTH = 8
);
    logic             enable;
    logic             dir;
    logic             one_shot;
    logic             load;
    logic [WIDTH-1:0] max_in;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             trig_out;
    logic             done;

    modport master (
        output enable, dir, one_shot, load, max_in,
        input  count, tc, trig_out, done
    );

    modport slave (
        input  enable, dir, one_shot, load, max_in,
        output count, tc, trig_out, done
    );
endinterface

// File: rtl/mode_counter.sv
// rtl/mode_counter.sv - up/down modulo counter with load, one-shot halt and cascade trigger
module mode_counter #(
    parameter int WIDTH       = 8,
    parameter int DEFAULT_MAX = 200,
    parameter int TRIG_MODE   = 0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    mode_counter_if.slave bus_io
);
    localparam logic [0:0]       ST_RUN  = 1'b0;
    localparam logic [0:0]       ST_HALT = 1'b1;
    localparam logic [WIDTH-1:0] MAX_RST = WIDTH'(DEFAULT_MAX);

    logic [WIDTH-1:0] count_q = '0;
    logic [WIDTH-1:0] max_q   = MAX_RST;
    logic [0:0]       state_q = ST_RUN;
    logic             tc_q    = 1'b0;
    logic             trig_q  = 1'b0;

    logic [WIDTH-1:0] count_d;
    logic [WIDTH-1:0] max_d;
    logic [0:0]       state_d;
    logic             tc_d;
    logic             trig_d;
    logic             at_end;

    // Terminal value depends on direction: top of range going up, zero going down
    assign at_end = bus_io.dir ? (count_q == '0) : (count_q == max_q);

    always_comb begin
        count_d = count_q;
        max_d   = max_q;
        state_d = state_q;
        tc_d    = 1'b0;
        if (bus_io.load) begin
            max_d   = bus_io.max_in;
            count_d = bus_io.dir ? bus_io.max_in : '0;
            state_d = ST_RUN;
        end else if (state_q == ST_RUN && bus_io.enable) begin
            if (at_end) begin
                tc_d = 1'b1;
                if (bus_io.one_shot) begin
                    state_d = ST_HALT;
                end else begin
                    count_d = bus_io.dir ? max_q : '0;
                end
            end else begin
                count_d = bus_io.dir ? count_q - 1'b1 : count_q + 1'b1;
            end
        end
    end

    // Toggle mode flips on every terminal event; pulse mode mirrors TC
    generate
        if (TRIG_MODE == 0) begin : g_toggle
            assign trig_d = trig_q ^ tc_d;
        end else begin : g_pulse
            assign trig_d = tc_d;
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q <= '0;
            max_q   <= MAX_RST;
            state_q <= ST_RUN;
            tc_q    <= 1'b0;
            trig_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            max_q   <= max_d;
            state_q <= state_d;
            tc_q    <= tc_d;
            trig_q  <= trig_d;
        end
    end

    assign bus_io.count    = count_q;
    assign bus_io.tc       = tc_q;
    assign bus_io.trig_out = trig_q;
    assign bus_io.done     = (state_q == ST_HALT);
endmodule

// File: tb/tb_mode_counter.sv
// tb/tb_mode_counter.sv - directed checks of mode_counter in toggle and pulse trigger modes
module tb_mode_counter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    mode_counter_if #(.WIDTH(4)) u_if0 ();
    mode_counter_if #(.WIDTH(4)) u_if1 ();

    assign u_if1.enable   = u_if0.enable;
    assign u_if1.dir      = u_if0.dir;
    assign u_if1.one_shot = u_if0.one_shot;
    assign u_if1.load     = u_if0.load;
    assign u_if1.max_in   = u_if0.max_in;

    mode_counter #(.WIDTH(4), .DEFAULT_MAX(4), .TRIG_MODE(0)) u_dut0 (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(u_if0.slave)
    );

    mode_counter #(.WIDTH(4), .DEFAULT_MAX(4), .TRIG_MODE(1)) u_dut1 (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(u_if1.slave)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic dir_v);
        rst = 1'b1;
        u_if0.enable = 1'b0; u_if0.dir = dir_v; u_if0.one_shot = 1'b0;
        u_if0.load = 1'b0; u_if0.max_in = 4'd0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        #1;
        checks++;
        if (u_if0.count !== 4'd0 || u_if0.tc !== 1'b0 || u_if0.trig_out !== 1'b0 || u_if0.done !== 1'b0) begin
            errors++;
            $display("FAIL powerup: got count=%0d tc=%b trig=%b done=%b expected 0 0 0 0",
                     u_if0.count, u_if0.tc, u_if0.trig_out, u_if0.done);
        end
        u_if0.enable = 1'b1; u_if0.dir = 1'b1; u_if0.one_shot = 1'b1;
        u_if0.load = 1'b1; u_if0.max_in = 4'd9;
        tick();
        checks++;
        if (u_if0.count !== 4'd0 || u_if0.tc !== 1'b0 || u_if0.trig_out !== 1'b0 || u_if0.done !== 1'b0) begin
            errors++;
            $display("FAIL reset: got count=%0d tc=%b trig=%b done=%b expected 0 0 0 0",
                     u_if0.count, u_if0.tc, u_if0.trig_out, u_if0.done);
        end
    endtask

    task automatic test_up_free_run();
        int exp_c[12] = '{1, 2, 3, 4, 0, 1, 2, 3, 4, 0, 1, 2};
        int exp_t[12] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 0, 0};
        do_reset(1'b0);
        u_if0.enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            tick();
            checks++;
            if (u_if0.count !== 4'(exp_c[i]) || u_if0.tc !== (exp_c[i] == 0)
                || u_if0.trig_out !== 1'(exp_t[i])) begin
                errors++;
                $display("FAIL up_free_run[%0d]: got count=%0d tc=%b trig=%b expected %0d %b %0d",
                         i, u_if0.count, u_if0.tc, u_if0.trig_out, exp_c[i], exp_c[i] == 0, exp_t[i]);
            end
        end
    endtask

    task automatic test_pulse_mode();
        do_reset(1'b0);
        u_if0.enable = 1'b1;
        for (int i = 0; i < 15; i++) begin
            tick();
            checks++;
            if (u_if1.trig_out !== (i % 5 == 4) || u_if1.tc !== (i % 5 == 4)) begin
                errors++;
                $display("FAIL pulse_mode[%0d]: got trig=%b tc=%b expected %b", i,
                         u_if1.trig_out, u_if1.tc, i % 5 == 4);
            end
        end
    endtask

    task automatic test_enable_hold();
        do_reset(1'b0);
        u_if0.enable = 1'b1;
        tick(); tick();
        u_if0.enable = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (u_if0.count !== 4'd2 || u_if0.tc !== 1'b0) begin
                errors++;
                $display("FAIL enable_hold[%0d]: got count=%0d tc=%b expected 2 0", i, u_if0.count, u_if0.tc);
            end
        end
    endtask

    task automatic test_one_shot_then_reset();
        int exp_c[8] = '{2, 1, 0, 0, 0, 0, 0, 0};
        do_reset(1'b0);
        u_if0.load = 1'b1; u_if0.max_in = 4'd3; u_if0.dir = 1'b1;
        u_if0.one_shot = 1'b1; u_if0.enable = 1'b1;
        tick();
        checks++;
        if (u_if0.count !== 4'd3 || u_if0.tc !== 1'b0 || u_if0.done !== 1'b0) begin
            errors++;
            $display("FAIL one_shot_load: got count=%0d tc=%b done=%b expected 3 0 0",
                     u_if0.count, u_if0.tc, u_if0.done);
        end
        u_if0.load = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (i >= 4) begin
                u_if0.dir = i[0];
                u_if0.enable = i[1];
                u_if0.one_shot = i[0];
            end
            tick();
            checks++;
            if (u_if0.count !== 4'(exp_c[i]) || u_if0.tc !== (i == 3) || u_if0.done !== (i >= 3)
                || u_if0.trig_out !== (i >= 3)) begin
                errors++;
                $display("FAIL one_shot[%0d]: got count=%0d tc=%b done=%b trig=%b expected %0d %b %b %b",
                         i, u_if0.count, u_if0.tc, u_if0.done, u_if0.trig_out,
                         exp_c[i], i == 3, i >= 3, i >= 3);
            end
        end
        rst = 1'b1; u_if0.load = 1'b1; u_if0.max_in = 4'd7;
        u_if0.dir = 1'b0; u_if0.one_shot = 1'b0; u_if0.enable = 1'b1;
        tick();
        checks++;
        if (u_if0.count !== 4'd0 || u_if0.tc !== 1'b0 || u_if0.trig_out !== 1'b0 || u_if0.done !== 1'b0) begin
            errors++;
            $display("FAIL reset_from_halt: got count=%0d tc=%b trig=%b done=%b expected 0 0 0 0",
                     u_if0.count, u_if0.tc, u_if0.trig_out, u_if0.done);
        end
        rst = 1'b0; u_if0.load = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if (u_if0.count !== 4'((i + 1) % 5) || u_if0.tc !== (i == 4)) begin
                errors++;
                $display("FAIL post_reset_wrap[%0d]: got count=%0d tc=%b expected %0d %b",
                         i, u_if0.count, u_if0.tc, (i + 1) % 5, i == 4);
            end
        end
    endtask

    task automatic test_load_collision();
        int exp_c[9] = '{1, 2, 3, 4, 5, 6, 7, 0, 1};
        do_reset(1'b0);
        u_if0.enable = 1'b1;
        for (int i = 0; i < 7; i++) tick();
        u_if0.load = 1'b1; u_if0.max_in = 4'd7;
        tick();
        checks++;
        if (u_if0.count !== 4'd0 || u_if0.tc !== 1'b0 || u_if0.trig_out !== 1'b1 || u_if1.trig_out !== 1'b0) begin
            errors++;
            $display("FAIL load_collision: got count=%0d tc=%b trig0=%b trig1=%b expected 0 0 1 0",
                     u_if0.count, u_if0.tc, u_if0.trig_out, u_if1.trig_out);
        end
        u_if0.load = 1'b0;
        for (int i = 0; i < 9; i++) begin
            tick();
            checks++;
            if (u_if0.count !== 4'(exp_c[i]) || u_if0.tc !== (i == 7)) begin
                errors++;
                $display("FAIL load_run[%0d]: got count=%0d tc=%b expected %0d %b",
                         i, u_if0.count, u_if0.tc, exp_c[i], i == 7);
            end
        end
    endtask

    task automatic test_dir_change();
        int exp_c[4] = '{2, 1, 0, 4};
        do_reset(1'b0);
        u_if0.enable = 1'b1;
        tick(); tick(); tick();
        u_if0.dir = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (u_if0.count !== 4'(exp_c[i]) || u_if0.tc !== (i == 3)) begin
                errors++;
                $display("FAIL dir_change[%0d]: got count=%0d tc=%b expected %0d %b",
                         i, u_if0.count, u_if0.tc, exp_c[i], i == 3);
            end
        end
    endtask

    task automatic test_reset_down();
        do_reset(1'b1);
        u_if0.enable = 1'b1;
        tick();
        checks++;
        if (u_if0.count !== 4'd4 || u_if0.tc !== 1'b1) begin
            errors++;
            $display("FAIL reset_down: got count=%0d tc=%b expected 4 1", u_if0.count, u_if0.tc);
        end
    endtask

    task automatic test_max_zero();
        do_reset(1'b0);
        u_if0.load = 1'b1; u_if0.max_in = 4'd0;
        tick();
        u_if0.load = 1'b0; u_if0.enable = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (u_if0.count !== 4'd0 || u_if0.tc !== 1'b1 || u_if0.trig_out !== (i % 2 == 0)) begin
                errors++;
                $display("FAIL max_zero[%0d]: got count=%0d tc=%b trig=%b expected 0 1 %b",
                         i, u_if0.count, u_if0.tc, u_if0.trig_out, i % 2 == 0);
            end
        end
    endtask

    initial begin
        test_reset();
        test_up_free_run();
        test_pulse_mode();
        test_enable_hold();
        test_one_shot_then_reset();
        test_load_collision();
        test_dir_change();
        test_reset_down();
        test_max_zero();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/mode_counter.md
MODE_COUNTER -- requirements
Module: mode_counter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, counter and maximum width in bits (1..32).
REQ-002 The block SHALL have parameter DEFAULT_MAX, default 200, maximum loaded at reset; SHALL fit in WIDTH bits.
REQ-003 The block SHALL have parameter TRIG_MODE, default 0, TRIG_OUT behaviour: 0 = toggle per terminal event, 1 = one-cycle pulse per terminal event.
REQ-004 The block SHALL have port CLK  in  1  master clock; all state SHALL update on its rising edge only.
REQ-005 The block SHALL have port RESET  in  1  reset, synchronous and active-high.
REQ-006 The block SHALL have port ENABLE  in  1  count-advance qualifier.
REQ-007 The block SHALL have port DIR  in  1  direction: 0 = up, 1 = down.
REQ-008 The block SHALL have port ONE_SHOT  in  1  mode: 0 = free-run wrap, 1 = stop after first terminal event.
REQ-009 The block SHALL have port LOAD  in  1  load MAX_IN as the new maximum and restart the count.
REQ-010 The block SHALL have port MAX_IN  in  WIDTH  new maximum value, sampled only when LOAD=1.
REQ-011 The block SHALL have port COUNT  out  WIDTH  current registered count.
REQ-012 The block SHALL have port TC  out  1  registered terminal-count pulse.
REQ-013 The block SHALL have port TRIG_OUT  out  1  cascade trigger per TRIG_MODE.
REQ-014 The block SHALL have port DONE  out  1  high while halted in one-shot mode.

Function
REQ-015 The block SHALL hold the maximum in an internal register MaxReg; counting range SHALL be 0..MaxReg inclusive (MaxReg+1 states).
REQ-016 The block SHALL implement two states, RUN and HALT; DONE SHALL be 1 exactly when the state is HALT.
REQ-017 In RUN with ENABLE=1, LOAD=0, the block SHALL advance COUNT by one per cycle: up 0->MaxReg then wrap to 0; down MaxReg->0 then wrap to MaxReg.
REQ-018 A terminal event SHALL be RUN and ENABLE=1 and LOAD=0 with COUNT==MaxReg (DIR=0) or COUNT==0 (DIR=1).
REQ-019 TC SHALL be 1 for exactly the one cycle in which COUNT shows the post-terminal-event value, and 0 otherwise.
REQ-020 With TRIG_MODE=0, TRIG_OUT SHALL invert on the same edge that TC rises; with TRIG_MODE=1, TRIG_OUT SHALL equal TC.
REQ-021 With ONE_SHOT=1, a terminal event SHALL leave COUNT at the terminal value (no wrap), assert TC once, and move the state to HALT.
REQ-022 In HALT, the block SHALL ignore ENABLE, DIR, and ONE_SHOT and hold COUNT, TRIG_OUT, and DONE; only LOAD or RESET SHALL exit HALT.
REQ-023 With ENABLE=0, COUNT and TRIG_OUT SHALL hold, and TC SHALL be 0.
REQ-024 LOAD=1 SHALL take priority over ENABLE: on the next edge, MaxReg SHALL take MAX_IN and COUNT SHALL take 0 (DIR=0) or MAX_IN (DIR=1).
REQ-025 LOAD=1 SHALL also set the state to RUN and force TC to 0 for that cycle, and SHALL leave TRIG_OUT unchanged in TRIG_MODE=0.
REQ-026 A DIR change mid-count SHALL continue from the current COUNT in the new direction, with no skipped or repeated value.
REQ-027 With MaxReg=0, every enabled RUN cycle SHALL be a terminal event, COUNT SHALL stay 0, and TC SHALL stay high while ENABLE remains 1.
REQ-028 All count arithmetic SHALL be modulo the explicit compare against MaxReg/0; COUNT SHALL never exceed MaxReg, and no WIDTH-bit overflow SHALL occur.

Reset
REQ-029 On RESET=1 at a clock edge, the block SHALL set COUNT=0, TC=0, TRIG_OUT=0, DONE=0, state=RUN, MaxReg=DEFAULT_MAX, regardless of all other inputs including LOAD.
REQ-030 In reset with DIR=1, the first enabled cycle after release SHALL be a terminal event (COUNT=0), wrapping COUNT to MaxReg.
REQ-031 All registers SHALL also carry the same power-up initial values as REQ-029.

Verification (WIDTH=4, DEFAULT_MAX=4 unless stated)
REQ-032 Up free-run: reset, then ENABLE=1 for 12 cycles -> COUNT 1,2,3,4,0,1,2,3,4,0,1,2; TC high on both cycles COUNT=0; TRIG_OUT (mode 0) 0->1->0.
REQ-033 Pulse mode (TRIG_MODE=1): ENABLE=1 for 15 cycles -> TRIG_OUT one-cycle high every 5 cycles, coincident with TC.
REQ-034 One-shot down: LOAD with MAX_IN=3, DIR=1, ONE_SHOT=1, then ENABLE=1 for 8 cycles -> COUNT 3,2,1,0,0,0...; TC once; DONE=1 and held; toggling DIR or ENABLE has no effect.
REQ-035 LOAD+ENABLE collision at COUNT=2, DIR=0, MAX_IN=7 -> next COUNT=0, no TC; the count then runs 1..7, with wrap at 7.
REQ-036 Reset mid-operation from HALT with TRIG_OUT=1, plus LOAD=1 simultaneously -> COUNT=0, TC=0, TRIG_OUT=0, DONE=0; the next wrap occurs at 4.
REQ-037 LOAD MAX_IN=0, DIR=0, ONE_SHOT=0, ENABLE=1 for 4 cycles -> COUNT stays 0, TC high for 4 cycles, TRIG_OUT (mode 0) alternates 1,0,1,0.
